// File: rtl/intra_sched_pkg.sv
// Shared types and constants for the 4-tap intra angular filter sequencer.
package intra_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int NTAPS     = 4;
  localparam int PIX_W     = 8;
  localparam int PROD_W    = 16;
  localparam int SEL_W     = 3;
  localparam int MCM_OUTS  = 8;
  localparam int DEF_ACC_W = 18;
  localparam int DEF_SHIFT = 6;

endpackage

// File: rtl/intra_round_clip.sv
// Combinational round-half-up, arithmetic shift and optional [0,255] clamp.
// Clamp is enabled by defining INTRA_SCHED_CLIP_EN.
module intra_round_clip
  import intra_sched_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [PROD_W-1:0] pred_o
);

  // One guard bit so the rounding offset cannot overflow the accumulator width.
  localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << PIX_W) - 1);

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  assign sum     = {acc_i[ACC_W-1], acc_i} + RND;
  assign shifted = sum >>> SHIFT;

`ifdef INTRA_SCHED_CLIP_EN
  always_comb begin
    pred_o = PROD_W'(shifted);
    if (shifted < 0) begin
      pred_o = '0;
    end else if (shifted > MAX_V) begin
      pred_o = PROD_W'(MAX_V);
    end
  end
`else
  assign pred_o = PROD_W'(shifted);
`endif

endmodule

// File: rtl/intra_filter_sched.sv
// Time-shares one 8-output MCM bank across four taps to produce one intra sample.
// Output clamping is selected by INTRA_SCHED_CLIP_EN (see intra_round_clip).
module intra_filter_sched
  import intra_sched_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [NTAPS*PIX_W-1:0]       req_refs,
  input  logic [NTAPS*SEL_W-1:0]       req_sel,
  output logic [PIX_W-1:0]             mcm_x,
  input  logic [MCM_OUTS*PROD_W-1:0]   mcm_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [PROD_W-1:0]     out_pred,
  output logic                         busy
);

  state_t                      state_q, state_d;
  logic [1:0]                  tap_q, tap_d;
  logic [NTAPS*PIX_W-1:0]      refs_q, refs_d;
  logic [NTAPS*SEL_W-1:0]      sel_q, sel_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [PROD_W-1:0]    pred_q, pred_d;

  logic [PIX_W-1:0]            ref_arr [NTAPS];
  logic [SEL_W-1:0]            sel_arr [NTAPS];
  logic signed [PROD_W-1:0]    prod_arr [MCM_OUTS];
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [PROD_W-1:0]    pred_rc;
  logic                        accept;

  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
      assign ref_arr[gi] = refs_q[gi*PIX_W +: PIX_W];
      assign sel_arr[gi] = sel_q[gi*SEL_W +: SEL_W];
    end
    for (genvar gi = 0; gi < MCM_OUTS; gi++) begin : g_prod
      assign prod_arr[gi] = mcm_y[gi*PROD_W +: PROD_W];
    end
  endgenerate

  assign prod    = prod_arr[sel_arr[tap_q]];
  assign acc_sum = acc_q + ACC_W'(prod);

  intra_round_clip #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_round_clip (
    .acc_i  (acc_sum),
    .pred_o (pred_rc)
  );

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    refs_d  = refs_q;
    sel_d   = sel_q;
    acc_d   = acc_q;
    pred_d  = pred_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: accept = req_valid;
      FEED: begin
        acc_d = acc_sum;
        tap_d = tap_q + 2'd1;
        if (tap_q == 2'(NTAPS-1)) begin
          pred_d  = pred_rc;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (req_valid) accept  = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      refs_d  = req_refs;
      sel_d   = req_sel;
      acc_d   = '0;
      tap_d   = '0;
      state_d = FEED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      refs_q  <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      pred_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      refs_q  <= refs_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      pred_q  <= pred_d;
    end
  end

  // req_ready is gated by rst so it reads 0 while reset is held, not just after.
  assign req_ready = !rst && ((state_q == IDLE) || ((state_q == OUT) && out_ready));
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign mcm_x     = (state_q == FEED) ? ref_arr[tap_q] : '0;
  assign out_pred  = pred_q;

endmodule

// File: tb/tb_intra_filter_sched.sv
// Directed bench for intra_filter_sched with a behavioural 8-coefficient MCM model.
module tb_intra_filter_sched;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [31:0]        req_refs = '0;
  logic [11:0]        req_sel = '0;
  logic [7:0]         mcm_x;
  logic [127:0]       mcm_y;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_pred;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;
  int coef [8] = '{-3, 8, 36, 24, 34, 23, -3, 7};

`ifdef INTRA_SCHED_CLIP_EN
  localparam int EXP_HI = 255;
  localparam int EXP_LO = 0;
`else
  localparam int EXP_HI = 279;
  localparam int EXP_LO = -24;
`endif

  always #5 clk = ~clk;

  always_comb begin
    mcm_y = '0;
    for (int i = 0; i < 8; i++) begin
      mcm_y[16*i +: 16] = 16'(coef[i] * int'(mcm_x));
    end
  end

  intra_filter_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_refs  (req_refs),
    .req_sel   (req_sel),
    .mcm_x     (mcm_x),
    .mcm_y     (mcm_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pred  (out_pred),
    .busy      (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] refs4(input int r0, input int r1, input int r2, input int r3);
    return {8'(r3), 8'(r2), 8'(r1), 8'(r0)};
  endfunction

  function automatic logic [11:0] sel4(input int s0, input int s1, input int s2, input int s3);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  // Present a request and step into the first FEED cycle (T+1).
  task automatic issue(input logic [31:0] refs, input logic [11:0] sel, input string tag);
    req_refs  = refs;
    req_sel   = sel;
    req_valid = 1'b1;
    #1;
    check({tag, " req_ready"}, int'(req_ready), 1);
    tick;
    req_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  // Walk T+1..T+4; on return the bench sits at T+5.
  task automatic feed(input logic [31:0] refs, input int hold_pred, input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s mcm_x%0d", tag, k), int'(mcm_x), int'(refs[8*k +: 8]));
      check($sformatf("%s feed_valid%0d", tag, k), int'(out_valid), 0);
      check($sformatf("%s feed_pred%0d", tag, k), int'(out_pred), hold_pred);
      tick;
    end
  endtask

  task automatic finish_out(input int exp, input string tag);
    check({tag, " out_valid"}, int'(out_valid), 1);
    check({tag, " out_pred"}, int'(out_pred), exp);
    check({tag, " mcm_x_out"}, int'(mcm_x), 0);
    out_ready = 1'b1;
    #1;
    check({tag, " ready_in_out"}, int'(req_ready), 1);
    tick;
    out_ready = 1'b0;
    #1;
    check({tag, " idle_valid"}, int'(out_valid), 0);
    check({tag, " idle_busy"}, int'(busy), 0);
    check({tag, " idle_mcm_x"}, int'(mcm_x), 0);
  endtask

  task automatic run(input logic [31:0] refs, input logic [11:0] sel, input int exp,
                     input string tag);
    int prev;
    prev = int'(out_pred);
    issue(refs, sel, tag);
    feed(refs, prev, tag);
    finish_out(exp, tag);
  endtask

  initial begin
    tick;
    check("rst req_ready", int'(req_ready), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_pred", int'(out_pred), 0);
    check("rst mcm_x", int'(mcm_x), 0);
    check("rst busy", int'(busy), 0);
    tick;
    rst = 1'b0;
    #1;
    check("post_rst req_ready", int'(req_ready), 1);

    run(refs4(100, 100, 100, 100), sel4(0, 2, 4, 0), 100,    "flat");
    run(refs4(10, 20, 30, 40),     sel4(1, 3, 5, 7), 24,     "ramp");
    run(refs4(0, 255, 255, 0),     sel4(0, 2, 4, 0), EXP_HI, "hi");
    run(refs4(255, 0, 0, 255),     sel4(0, 2, 4, 0), EXP_LO, "lo");

    // Backpressure in OUT, then back-to-back acceptance on the releasing cycle.
    issue(refs4(10, 20, 30, 40), sel4(1, 3, 5, 7), "hold_a");
    feed(refs4(10, 20, 30, 40), EXP_LO, "hold_a");
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d out_valid", c), int'(out_valid), 1);
      check($sformatf("stall%0d out_pred", c), int'(out_pred), 24);
      check($sformatf("stall%0d req_ready", c), int'(req_ready), 0);
      tick;
    end
    out_ready = 1'b1;
    issue(refs4(100, 100, 100, 100), sel4(0, 2, 4, 0), "b2b");
    feed(refs4(100, 100, 100, 100), 24, "b2b");
    finish_out(100, "b2b");

    // Asynchronous reset in the middle of FEED (T+2).
    issue(refs4(0, 255, 255, 0), sel4(0, 2, 4, 0), "abort");
    tick;
    check("abort busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort req_ready", int'(req_ready), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_pred", int'(out_pred), 0);
    check("abort mcm_x", int'(mcm_x), 0);
    check("abort busy", int'(busy), 0);
    tick;
    rst = 1'b0;
    #1;
    check("abort req_ready_rise", int'(req_ready), 1);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("abort quiet%0d", c), int'(out_valid), 0);
      tick;
    end
    run(refs4(10, 20, 30, 40), sel4(1, 3, 5, 7), 24, "fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
